// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch instruction queue: core config, decode entry and realigner slots.
package fetch_queue_pkg;

  localparam int unsigned HALF_W   = 16;
  localparam int unsigned VLEN_DEF = 32;
  localparam int unsigned XLEN_DEF = 32;

  typedef struct packed {
    int unsigned VLEN;
    int unsigned XLEN;
  } cfg_t;

  localparam cfg_t cva6_cfg_empty = '{VLEN: VLEN_DEF, XLEN: XLEN_DEF};

  typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;

  typedef struct packed {
    cf_t                 cf;
    logic [VLEN_DEF-1:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] cause;
    logic [XLEN_DEF-1:0] tval;
    logic                valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN_DEF-1:0] address;
    logic [31:0]         instruction;
    branchpredict_sbe_t  branch_predict;
    exception_t          ex;
  } fetch_entry_t;

  typedef struct packed {
    logic                valid;
    logic [31:0]         instr;
    logic [VLEN_DEF-1:0] addr;
  } realign_slot_t;

  typedef realign_slot_t [1:0] realign_out_t;

  function automatic logic is_compressed(input logic [HALF_W-1:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_instr_queue_realign.sv
// Realigner: splits a fetch word into up to two instructions, carrying a straddling upper half.
module instr_realign
  import fetch_queue_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                flush_i,
  input  logic [31:0]         data_i,
  input  logic [VLEN_DEF-1:0] addr_i,
  input  logic                ex_valid_i,
  output realign_out_t        out_o
);

  logic                pend_valid_q, pend_valid_d;
  logic [HALF_W-1:0]   pend_half_q, pend_half_d;
  logic [VLEN_DEF-1:0] pend_addr_q, pend_addr_d;

  logic [HALF_W-1:0]   lo, hi;
  logic [VLEN_DEF-1:0] base;
  logic                use_hi, hi_idx;
  logic                nxt_valid;
  logic [HALF_W-1:0]   nxt_half;
  logic [VLEN_DEF-1:0] nxt_addr;

  always_comb begin
    out_o     = '0;
    lo        = data_i[15:0];
    hi        = data_i[31:16];
    base      = {addr_i[VLEN_DEF-1:2], 2'b00};
    use_hi    = 1'b0;
    hi_idx    = 1'b0;
    nxt_valid = 1'b0;
    nxt_half  = pend_half_q;
    nxt_addr  = pend_addr_q;

    if (ex_valid_i) begin
      out_o[0] = '{valid: 1'b1, instr: '0, addr: addr_i};
    end else begin
      if (pend_valid_q) begin
        out_o[0] = '{valid: 1'b1, instr: {lo, pend_half_q}, addr: pend_addr_q};
        use_hi   = 1'b1;
        hi_idx   = 1'b1;
      end else if (!addr_i[1]) begin
        if (is_compressed(lo)) begin
          out_o[0] = '{valid: 1'b1, instr: {16'h0, lo}, addr: base};
          use_hi   = 1'b1;
          hi_idx   = 1'b1;
        end else begin
          out_o[0] = '{valid: 1'b1, instr: data_i, addr: base};
        end
      end else begin
        use_hi = 1'b1;
      end
      // A 32-bit upper half becomes the low half of the next word's instruction.
      if (use_hi) begin
        if (is_compressed(hi)) begin
          out_o[hi_idx] = '{valid: 1'b1, instr: {16'h0, hi}, addr: base + VLEN_DEF'(2)};
        end else begin
          nxt_valid = 1'b1;
          nxt_half  = hi;
          nxt_addr  = base + VLEN_DEF'(2);
        end
      end
    end

    pend_valid_d = pend_valid_q;
    pend_half_d  = pend_half_q;
    pend_addr_d  = pend_addr_q;
    if (flush_i) begin
      pend_valid_d = 1'b0;
    end else if (en_i) begin
      pend_valid_d = nxt_valid;
      pend_half_d  = nxt_half;
      pend_addr_d  = nxt_addr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_half_q  <= '0;
      pend_addr_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_half_q  <= pend_half_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

endmodule

// File: rtl/fetch_instr_queue.sv
// Fetch instruction queue: realigner feeding a DEPTH-entry FIFO towards decode.
// Optional same-cycle bypass of an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_instr_queue
  import fetch_queue_pkg::*;
#(
  parameter cfg_t        CVA6Cfg       = cva6_cfg_empty,
  parameter type         fetch_entry_t = fetch_queue_pkg::fetch_entry_t,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    fetch_valid_i,
  output logic                    fetch_ready_o,
  input  logic [31:0]             fetch_data_i,
  input  logic [CVA6Cfg.VLEN-1:0] fetch_addr_i,
  input  logic                    fetch_ex_valid_i,
  input  logic [CVA6Cfg.XLEN-1:0] fetch_ex_cause_i,
  output fetch_entry_t            fetch_entry_o,
  output logic                    fetch_entry_valid_o,
  input  logic                    fetch_entry_ready_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t       mem_q [DEPTH];
  fetch_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept, empty, bypass_act, bypass_take, pop_fifo;
  logic               wr0_en, wr1_en;
  realign_out_t       slots;
  fetch_entry_t       e0, e1, wr0, wr1;

  assign empty         = (cnt_q == '0);
  assign fetch_ready_o = (cnt_q <= CNT_W'(DEPTH - 2)) && !flush_i;
  assign accept        = fetch_valid_i && fetch_ready_o;

  instr_realign u_realign (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (accept),
    .flush_i    (flush_i),
    .data_i     (fetch_data_i),
    .addr_i     (fetch_addr_i),
    .ex_valid_i (fetch_ex_valid_i),
    .out_o      (slots)
  );

  always_comb begin
    e0             = '0;
    e0.address     = slots[0].addr;
    e0.instruction = slots[0].instr;
    if (fetch_ex_valid_i) begin
      e0.ex.valid = 1'b1;
      e0.ex.cause = fetch_ex_cause_i;
      e0.ex.tval  = fetch_addr_i;
    end
    e1             = '0;
    e1.address     = slots[1].addr;
    e1.instruction = slots[1].instr;
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_act = empty && accept && slots[0].valid;
`else
  assign bypass_act = 1'b0;
`endif
  assign bypass_take = bypass_act && fetch_entry_ready_i;

  always_comb begin
    fetch_entry_valid_o = (!empty || bypass_act) && !flush_i;
    if (!empty)          fetch_entry_o = mem_q[rptr_q];
    else if (bypass_act) fetch_entry_o = e0;
    else                 fetch_entry_o = '0;
  end

  assign pop_fifo = fetch_entry_valid_o && fetch_entry_ready_i && !empty;

  // A bypassed first instruction is consumed directly, so only the second slot is stored.
  always_comb begin
    if (bypass_take) begin
      wr0_en = accept && slots[1].valid;
      wr0    = e1;
      wr1_en = 1'b0;
      wr1    = e1;
    end else begin
      wr0_en = accept && slots[0].valid;
      wr0    = e0;
      wr1_en = accept && slots[1].valid;
      wr1    = e1;
    end

    mem_d = mem_q;
    if (wr0_en) mem_d[wptr_q] = wr0;
    if (wr1_en) mem_d[PTR_W'(wptr_q + PTR_W'(1))] = wr1;

    wptr_d = wptr_q + PTR_W'(wr0_en) + PTR_W'(wr1_en);
    rptr_d = rptr_q + PTR_W'(pop_fifo);
    cnt_d  = cnt_q + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(pop_fifo);

    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
